// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection, flush/hold control and optional STALL_COUNTER_EN stall counter
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef STALL_COUNTER_EN
  input  logic              cnt_clr,
  output logic [31:0]       stall_cnt,
`endif
  input  logic              id_alusrc,
  input  logic              id_memwrite,
  input  logic              id_memread,
  input  logic              id_beq,
  input  logic              id_jump,
  input  logic              id_regwrite,
  input  logic [1:0]        id_regdst,
  input  logic [1:0]        id_memtoreg,
  input  logic [2:0]        id_aluop,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [5:0]        id_funct,
  input  logic              flush,
  input  logic              hold,
  output logic              ex_alusrc,
  output logic              ex_memwrite,
  output logic              ex_memread,
  output logic              ex_beq,
  output logic              ex_jump,
  output logic              ex_regwrite,
  output logic [1:0]        ex_regdst,
  output logic [1:0]        ex_memtoreg,
  output logic [2:0]        ex_aluop,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [5:0]        ex_funct,
  output logic [REG_W-1:0]  ex_dest,
  output logic              ex_valid,
  output logic              pc_write,
  output logic              ifid_write
);
  typedef struct packed {
    logic              alusrc;
    logic              memwrite;
    logic              memread;
    logic              beq;
    logic              jump;
    logic              regwrite;
    logic [1:0]        regdst;
    logic [1:0]        memtoreg;
    logic [2:0]        aluop;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [5:0]        funct;
    logic [REG_W-1:0]  dest;
    logic              valid;
  } stage_t;
  stage_t q, d;
  logic lu;
  assign lu = q.valid & q.memread & (q.rt != '0) & ((q.rt == id_rs) | (q.rt == id_rt));
  assign pc_write = ~(lu | hold);
  assign ifid_write = pc_write;
  assign {ex_alusrc, ex_memwrite, ex_memread, ex_beq, ex_jump, ex_regwrite, ex_regdst, ex_memtoreg,
          ex_aluop, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct,
          ex_dest, ex_valid} = q;
  // Build the capture word; regdst 3 resolves to r0 and never writes back
  always_comb begin
    d = '{alusrc: id_alusrc, memwrite: id_memwrite, memread: id_memread, beq: id_beq,
          jump: id_jump, regwrite: id_regwrite & (id_regdst != 2'd3), regdst: id_regdst,
          memtoreg: id_memtoreg, aluop: id_aluop, pc4: id_pc4, rs_data: id_rs_data,
          rt_data: id_rt_data, imm: id_imm, rs: id_rs, rt: id_rt, rd: id_rd, funct: id_funct,
          dest: '0, valid: 1'b1};
    d.dest = id_regdst == 2'd0 ? id_rt : id_regdst == 2'd1 ? id_rd : id_regdst == 2'd2 ? REG_W'(31) : '0;
  end
  // Pipeline register: flush beats hold, hold beats the load-use bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (flush) q <= '0;
    else if (!hold) q <= lu ? '0 : d;
  end
`ifdef STALL_COUNTER_EN
  // Saturating count of load-use stall cycles not masked by an external hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (cnt_clr) stall_cnt <= '0;
    else if (lu && !hold && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a behavioural model
module tb_id_ex_stage;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, hold = 1'b0;
  logic [12:0] i_ctrl = '0;
  logic [31:0] i_pc4 = '0, i_rsd = '0, i_rtd = '0, i_imm = '0;
  logic [4:0] i_rs = '0, i_rt = '0, i_rd = '0;
  logic [5:0] i_funct = '0;
  logic ex_alusrc, ex_memwrite, ex_memread, ex_beq, ex_jump, ex_regwrite, ex_valid, pc_write, ifid_write;
  logic [1:0] ex_regdst, ex_memtoreg;
  logic [2:0] ex_aluop;
  logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0] ex_rs, ex_rt, ex_rd, ex_dest;
  logic [5:0] ex_funct;
  int checks = 0, failures = 0;
  logic [12:0] m_ctrl;
  logic [31:0] m_pc4, m_rsd, m_rtd, m_imm;
  logic [4:0] m_rs, m_rt, m_rd, m_dest;
  logic [5:0] m_funct;
  logic m_valid;
  logic [4:0] saved_dest;
  logic [31:0] saved_imm;
`ifdef STALL_COUNTER_EN
  logic cnt_clr = 1'b0;
  logic [31:0] stall_cnt, m_cnt;
`endif
  localparam logic [12:0] C_ADD = {6'b000001, 2'd1, 2'd0, 3'd4};
  localparam logic [12:0] C_LW  = {6'b101001, 2'd0, 2'd1, 3'd0};
  localparam logic [12:0] C_SW  = {6'b110000, 2'd0, 2'd0, 3'd0};
  localparam logic [12:0] C_JAL = {6'b000011, 2'd2, 2'd2, 3'd0};
  localparam logic [12:0] C_R3  = {6'b000001, 2'd3, 2'd0, 3'd4};

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
`ifdef STALL_COUNTER_EN
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt),
`endif
    .id_alusrc(i_ctrl[12]), .id_memwrite(i_ctrl[11]), .id_memread(i_ctrl[10]), .id_beq(i_ctrl[9]),
    .id_jump(i_ctrl[8]), .id_regwrite(i_ctrl[7]), .id_regdst(i_ctrl[6:5]), .id_memtoreg(i_ctrl[4:3]),
    .id_aluop(i_ctrl[2:0]), .id_pc4(i_pc4), .id_rs_data(i_rsd), .id_rt_data(i_rtd), .id_imm(i_imm),
    .id_rs(i_rs), .id_rt(i_rt), .id_rd(i_rd), .id_funct(i_funct), .flush(flush), .hold(hold),
    .ex_alusrc(ex_alusrc), .ex_memwrite(ex_memwrite), .ex_memread(ex_memread), .ex_beq(ex_beq),
    .ex_jump(ex_jump), .ex_regwrite(ex_regwrite), .ex_regdst(ex_regdst), .ex_memtoreg(ex_memtoreg),
    .ex_aluop(ex_aluop), .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .ex_dest(ex_dest), .ex_valid(ex_valid), .pc_write(pc_write), .ifid_write(ifid_write)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    {m_ctrl, m_pc4, m_rsd, m_rtd, m_imm, m_rs, m_rt, m_rd, m_dest, m_funct, m_valid} = '0;
  endtask

  function automatic bit model_lu();
    return m_valid && m_ctrl[10] && m_rt != 0 && (m_rt == i_rs || m_rt == i_rt);
  endfunction

  task automatic check_all();
    chk("ctrl", {ex_alusrc, ex_memwrite, ex_memread, ex_beq, ex_jump, ex_regwrite, ex_regdst, ex_memtoreg, ex_aluop}, m_ctrl);
    chk("pc4", ex_pc4, m_pc4);
    chk("rs_data", ex_rs_data, m_rsd);
    chk("rt_data", ex_rt_data, m_rtd);
    chk("imm", ex_imm, m_imm);
    chk("regs", {ex_rs, ex_rt, ex_rd, ex_funct}, {m_rs, m_rt, m_rd, m_funct});
    chk("dest", ex_dest, m_dest);
    chk("valid", ex_valid, m_valid);
`ifdef STALL_COUNTER_EN
    chk("stall_cnt", stall_cnt, m_cnt);
`endif
  endtask

  task automatic cycle();
    logic [4:0] dest_tab [4];
    bit lu;
    #1;
    lu = model_lu();
    chk("pc_write", pc_write, !(lu || hold));
    chk("ifid_write", ifid_write, !(lu || hold));
`ifdef STALL_COUNTER_EN
    if (cnt_clr) m_cnt = 0;
    else if (lu && !hold && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
    dest_tab = '{i_rt, i_rd, 5'd31, 5'd0};
    if (flush || (!hold && lu)) model_clear();
    else if (!hold) begin
      m_ctrl = i_ctrl;
      if (i_ctrl[6:5] == 2'd3) m_ctrl[7] = 1'b0;
      {m_pc4, m_rsd, m_rtd, m_imm, m_rs, m_rt, m_rd, m_funct} = {i_pc4, i_rsd, i_rtd, i_imm, i_rs, i_rt, i_rd, i_funct};
      m_dest = dest_tab[i_ctrl[6:5]];
      m_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_id(input logic [12:0] c, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    i_ctrl = c; i_rs = rs; i_rt = rt; i_rd = rd;
    i_pc4 = $urandom; i_rsd = $urandom; i_rtd = $urandom; i_imm = $urandom; i_funct = 6'($urandom);
  endtask

  initial begin
    model_clear();
`ifdef STALL_COUNTER_EN
    m_cnt = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    set_id(C_ADD, 5'd8, 5'd9, 5'd10);
    cycle();
    chk("add_dest", ex_dest, 5'd10);
    chk("add_aluop", ex_aluop, 3'd4);
    chk("add_valid", ex_valid, 1'b1);
    chk("add_pcw", pc_write, 1'b1);
    set_id(C_LW, 5'd8, 5'd9, 5'd0);
    cycle();
    set_id(C_ADD, 5'd9, 5'd11, 5'd10);
    #1;
    chk("lu_pcw", pc_write, 1'b0);
    chk("lu_ifidw", ifid_write, 1'b0);
    cycle();
    chk("lu_bubble", ex_valid, 1'b0);
    chk("lu_cleared", pc_write, 1'b1);
    cycle();
    chk("lu_retry_valid", ex_valid, 1'b1);
    chk("lu_retry_dest", ex_dest, 5'd10);
    set_id(C_LW, 5'd8, 5'd0, 5'd0);
    cycle();
    set_id(C_ADD, 5'd0, 5'd12, 5'd13);
    #1;
    chk("r0_pcw", pc_write, 1'b1);
    cycle();
    set_id(C_SW, 5'd3, 5'd4, 5'd0);
    flush = 1'b1; hold = 1'b1;
    cycle();
    chk("fh_memwrite", ex_memwrite, 1'b0);
    chk("fh_valid", ex_valid, 1'b0);
    flush = 1'b0; hold = 1'b0;
    set_id(C_ADD, 5'd5, 5'd6, 5'd7);
    cycle();
    saved_dest = ex_dest; saved_imm = ex_imm;
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_id(C_SW, 5'(k + 1), 5'd2, 5'd3);
      cycle();
    end
    chk("hold_dest", ex_dest, saved_dest);
    chk("hold_imm", ex_imm, saved_imm);
    chk("hold_valid", ex_valid, 1'b1);
    hold = 1'b0;
    set_id(C_JAL, 5'd0, 5'd0, 5'd0);
    cycle();
    chk("jal_dest", ex_dest, 5'd31);
    chk("jal_memtoreg", ex_memtoreg, 2'd2);
    set_id(C_R3, 5'd1, 5'd2, 5'd3);
    cycle();
    chk("rd3_regwrite", ex_regwrite, 1'b0);
    chk("rd3_dest", ex_dest, 5'd0);
`ifdef STALL_COUNTER_EN
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_id(C_LW, 5'd1, 5'd9, 5'd0);
      cycle();
      set_id(C_ADD, 5'd9, 5'd2, 5'd3);
      cycle();
    end
    chk("cnt_three", stall_cnt, 32'd3);
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    chk("cnt_clr", stall_cnt, 32'd0);
`endif
    for (int n = 0; n < 400; n++) begin
      set_id(13'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom));
      flush = $urandom_range(0, 9) == 0;
      hold = $urandom_range(0, 6) == 0;
`ifdef STALL_COUNTER_EN
      cnt_clr = $urandom_range(0, 19) == 0;
`endif
      cycle();
    end
    flush = 1'b0; hold = 1'b0;
    set_id({6'b111111, 2'd1, 2'd1, 3'd7}, 5'd21, 5'd22, 5'd23);
    cycle();
    chk("pre_rst_valid", ex_valid, 1'b1);
    flush = 1'b1; hold = 1'b1;
`ifdef STALL_COUNTER_EN
    cnt_clr = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #1;
    model_clear();
`ifdef STALL_COUNTER_EN
    m_cnt = 0;
`endif
    chk("rst_regwrite", ex_regwrite, 1'b0);
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_dest", ex_dest, 5'd0);
    check_all();
    #1 rst_n = 1'b1;
    flush = 1'b0; hold = 1'b0;
    set_id(C_ADD, 5'd8, 5'd9, 5'd10);
    cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
